// File: rtl/cnn_acc_pkg.sv
// Shared constants and FSM state type for the conv accumulator.
// Holds default widths, tap count, shift and acc_state_t.
package cnn_acc_pkg;

   localparam int PROD_W = 22;
   localparam int ACC_W  = 32;
   localparam int OUT_W  = 14;
   localparam int NTAPS  = 25;
   localparam int SHIFT  = 8;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      OUT
   } acc_state_t;

endpackage

// File: rtl/cnn_conv_acc_relu_if.sv
// Product-in / activation-out handshake bundle.
// slave: accumulator side; master: producer/consumer side.
interface cnn_conv_acc_relu_if #(
   parameter int PROD_W = cnn_acc_pkg::PROD_W,
   parameter int ACC_W  = cnn_acc_pkg::ACC_W,
   parameter int OUT_W  = cnn_acc_pkg::OUT_W
);

   logic                     prod_valid;
   logic                     prod_ready;
   logic signed [PROD_W-1:0] prod_data;
   logic signed [ACC_W-1:0]  bias;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [OUT_W-1:0]  out_data;
   logic                     busy;

   modport slave (
      input  prod_valid, prod_data, bias, out_ready,
      output prod_ready, out_valid, out_data, busy
   );

   modport master (
      output prod_valid, prod_data, bias, out_ready,
      input  prod_ready, out_valid, out_data, busy
   );

endinterface

// File: rtl/cnn_acc_round_sat.sv
// Round-half-up shift, optional ReLU and signed saturation.
// Ports: sum (ACC_W in) -> res (OUT_W out). ReLU under CNN_ACC_RELU_EN.
module cnn_acc_round_sat #(
   parameter int ACC_W = cnn_acc_pkg::ACC_W,
   parameter int OUT_W = cnn_acc_pkg::OUT_W,
   parameter int SHIFT = cnn_acc_pkg::SHIFT
) (
   input  logic signed [ACC_W-1:0] sum,
   output logic signed [OUT_W-1:0] res
);

   // One guard bit so adding the rounding half never wraps.
   localparam int RW = ACC_W + 1;

   localparam logic signed [RW-1:0] HALF =
      RW'(1) << (SHIFT - 1);
   localparam logic signed [RW-1:0] MAXV =
      (RW'(1) << (OUT_W - 1)) - RW'(1);
   localparam logic signed [RW-1:0] MINV =
      -(RW'(1) << (OUT_W - 1));

   logic signed [RW-1:0] ext;
   logic signed [RW-1:0] rnd;
   logic signed [RW-1:0] r;

   always_comb begin
      ext = {sum[ACC_W-1], sum};
      rnd = ext + HALF;
      r   = rnd >>> SHIFT;
`ifdef CNN_ACC_RELU_EN
      if (r < 0) begin
         r = '0;
      end
`endif
      if (r > MAXV) begin
         res = MAXV[OUT_W-1:0];
      end else if (r < MINV) begin
         res = MINV[OUT_W-1:0];
      end else begin
         res = r[OUT_W-1:0];
      end
   end

endmodule

// File: rtl/cnn_conv_acc_relu.sv
// Conv-output accumulator: bias + NTAPS products, round, ReLU, saturate.
// Ports: ap_clk, ap_rst_n (sync low), bus (slave). Macro: CNN_ACC_RELU_EN.
module cnn_conv_acc_relu #(
   parameter int PROD_W = cnn_acc_pkg::PROD_W,
   parameter int ACC_W  = cnn_acc_pkg::ACC_W,
   parameter int OUT_W  = cnn_acc_pkg::OUT_W,
   parameter int NTAPS  = cnn_acc_pkg::NTAPS,
   parameter int SHIFT  = cnn_acc_pkg::SHIFT
) (
   input logic                 ap_clk,
   input logic                 ap_rst_n,
   cnn_conv_acc_relu_if.slave  bus
);

   import cnn_acc_pkg::*;

   localparam int CW = $clog2(NTAPS + 1);

   acc_state_t              state;
   logic signed [ACC_W-1:0] acc;
   logic [CW-1:0]           tap_cnt;
   logic                    out_valid;
   logic signed [OUT_W-1:0] out_data;

   logic signed [ACC_W-1:0] prod_ext;
   logic signed [ACC_W-1:0] base;
   logic signed [ACC_W-1:0] sum_nxt;
   logic [CW-1:0]           cnt_nxt;
   logic                    last;
   logic signed [OUT_W-1:0] res;

   // First beat of an output starts from bias, later beats from acc.
   always_comb begin
      prod_ext = {{(ACC_W-PROD_W){bus.prod_data[PROD_W-1]}},
                  bus.prod_data};
      base     = (state == IDLE) ? bus.bias : acc;
      sum_nxt  = base + prod_ext;
      cnt_nxt  = (state == IDLE) ? CW'(1) : tap_cnt + CW'(1);
      last     = (cnt_nxt == CW'(NTAPS));
   end

   cnn_acc_round_sat #(
      .ACC_W (ACC_W),
      .OUT_W (OUT_W),
      .SHIFT (SHIFT)
   ) u_round_sat (
      .sum (sum_nxt),
      .res (res)
   );

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         state     <= IDLE;
         acc       <= '0;
         tap_cnt   <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         unique case (state)
            IDLE, ACCUM: begin
               if (bus.prod_valid) begin
                  acc     <= sum_nxt;
                  tap_cnt <= cnt_nxt;
                  if (last) begin
                     state     <= OUT;
                     out_valid <= 1'b1;
                     out_data  <= res;
                  end else begin
                     state <= ACCUM;
                  end
               end
            end
            OUT: begin
               if (bus.out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  tap_cnt   <= '0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.prod_ready = (state != OUT);
   assign bus.out_valid  = out_valid;
   assign bus.out_data   = out_data;
   assign bus.busy       = (state != IDLE);

endmodule

// File: doc/cnn_conv_acc_relu.md
CNN_CONV_ACC_RELU -- requirements
Module: cnn_conv_acc_relu

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- PROD_W, 22, signed product width from the 14s x 8s multiplier stage.
- ACC_W, 32, signed accumulator width.
- OUT_W, 14, signed output activation width.
- NTAPS, 25, products per output (5x5 kernel); legal range 1..256.
- SHIFT, 8, arithmetic right shift applied to the sum; legal range 1..ACC_W-OUT_W.

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- ap_clk, in, 1, the single clock; all logic is on its rising edge.
- ap_rst_n, in, 1, synchronous active-low reset.
- prod_valid, in, 1, a product beat is present.
- prod_ready, out, 1, the block accepts a product beat.
- prod_data, in, PROD_W, signed multiplier product.
- bias, in, ACC_W, signed bias; sampled only on the first beat of each output.
- out_valid, out, 1, an output result is present.
- out_ready, in, 1, the consumer accepts the result.
- out_data, out, OUT_W, signed activation.
- busy, out, 1, high whenever state is not IDLE.

Function
REQ-003 A beat SHALL transfer on a clock edge where prod_valid and prod_ready are both 1; a result SHALL transfer on an edge where out_valid and out_ready are both 1.
REQ-004 The state machine SHALL have three states: IDLE, ACCUM and OUT.
REQ-005 In IDLE and ACCUM, prod_ready SHALL be 1; in OUT, prod_ready SHALL be 0.
REQ-006 On the first beat in IDLE, the block SHALL set acc = bias + sext(prod_data) and tap_cnt = 1, then go to ACCUM; if NTAPS = 1, it SHALL go directly to OUT.
REQ-007 On each beat in ACCUM, the block SHALL set acc = acc + sext(prod_data) and increment tap_cnt. The beat that makes the total NTAPS SHALL be the last beat, and the block SHALL go to OUT on it.
REQ-008 Idle cycles (prod_valid = 0) SHALL NOT change acc, tap_cnt or state.
REQ-009 Result computation:
- r = (final_sum + 2^(SHIFT-1)) >>> SHIFT (round half up, arithmetic shift).
- Then apply the ReLU rule (REQ-016).
- Then saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-010 out_data SHALL be registered on the edge that accepts the last beat, and out_valid SHALL assert on that same edge, giving a latency of 1 cycle from the last beat.
REQ-011 out_valid and out_data SHALL remain stable while out_ready = 0. On a result transfer, the block SHALL return to IDLE and out_valid SHALL drop on the next edge.
REQ-012 Accumulator overflow SHALL wrap in two's complement and SHALL NOT be flagged; the defaults cannot overflow.
REQ-013 tap_cnt SHALL be sized as $clog2(NTAPS+1) bits and SHALL reset to 0 on entry to IDLE.

Reset
REQ-014 When ap_rst_n = 0 at an edge, the block SHALL set:
- state = IDLE, acc = 0, tap_cnt = 0;
- out_valid = 0, out_data = 0, busy = 0;
- prod_ready = 1 once ap_rst_n is released.
REQ-015 A reset during ACCUM or OUT SHALL discard the partial sum or pending result; the next beat SHALL start a new output.

Configuration
REQ-016 The macro CNN_ACC_RELU_EN SHALL control the ReLU:
- When defined, any negative r SHALL be clamped to 0 before saturation.
- When undefined, no clamp SHALL be applied, and the signed saturation range of REQ-009 applies in full.

Structure
REQ-017 A shared package cnn_acc_pkg SHALL hold:
- the default constants PROD_W, ACC_W, OUT_W, NTAPS and SHIFT;
- the state enum type acc_state_t {IDLE, ACCUM, OUT}.
REQ-018 Round, shift, ReLU and saturate SHALL live in one combinational sub-module, cnn_acc_round_sat. The FSM, counter, accumulator and output register SHALL be in cnn_conv_acc_relu.

Verification (defaults: NTAPS = 25, SHIFT = 8)
REQ-019 bias = 0, 25 beats of 256 -> out_data = 25 (sum 6400, plus 128 = 6528, shift gives 25), with out_valid one cycle after the 25th beat.
REQ-020 bias = 0, 25 beats of -256 -> out_data = 0 with CNN_ACC_RELU_EN, and -25 without it.
REQ-021 bias = 0, 25 beats of 2097151 -> out_data = 8191 (saturated); 25 beats of -2097152 without the macro -> -8192.
REQ-022 Hold out_ready = 0 for 10 cycles after out_valid asserts -> out_data stays constant, prod_ready = 0, and no beats are accepted; raising out_ready -> one transfer, then IDLE.
REQ-023 Pulse ap_rst_n low after 12 beats, then bias = 512 with 25 beats of 0 -> out_data = 2; no residue from the aborted sum.
REQ-024 Same stimulus as REQ-019 with random prod_valid gaps of 0-3 cycles -> out_data = 25.
